// File: rtl/alu_pkg.sv
// Shared ALU op-select encodings and requester ids for the ALU share arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;
  localparam int   NUM_REQ = 2;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; undefined op codes and NOP produce zero.
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      ALU_AND: result = data_1 & data_2;
      ALU_OR:  result = data_1 | data_2;
      ALU_ADD: result = data_1 + data_2;
      ALU_SUB: result = data_1 - data_2;
      ALU_SLT: result = {31'b0, data_1 < data_2};
      ALU_SLL: result = data_2 << shamt;
      ALU_SRL: result = data_2 >> shamt;
      ALU_SRA: result = $signed(data_2) >>> shamt;
      ALU_XOR: result = data_1 ^ data_2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters, each with a
// one-entry registered response slot that can drain and refill in one cycle.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter logic RR_INIT = 1'b0,
  parameter int   CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_sel,
  input  logic [31:0]      req0_data_1,
  input  logic [31:0]      req0_data_2,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_sel,
  input  logic [31:0]      req1_data_1,
  input  logic [31:0]      req1_data_2,
  input  logic [4:0]       req1_shamt,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_data,
  output logic             last_grant,
  output logic [CNT_W-1:0] op_count
);

  logic [NUM_REQ-1:0] req_valid, rsp_ready, slot_free, elig, accept;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [31:0]        rsp_data_reg [NUM_REQ];
  logic [3:0]         req_sel      [NUM_REQ];
  logic [31:0]        req_data_1   [NUM_REQ];
  logic [31:0]        req_data_2   [NUM_REQ];
  logic [4:0]         req_shamt    [NUM_REQ];

  logic               grant_valid, grant_id;
  logic               prio_reg, last_grant_reg;
  logic [CNT_W-1:0]   op_count_reg;
  logic [31:0]        alu_out;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_sel    = '{req0_sel, req1_sel};
  assign req_data_1 = '{req0_data_1, req1_data_1};
  assign req_data_2 = '{req0_data_2, req1_data_2};
  assign req_shamt  = '{req0_shamt, req1_shamt};

  // Pointer only breaks ties; a lone eligible requester always wins.
  always_comb begin
    grant_valid = |elig;
    grant_id    = prio_reg;
    if (elig == 2'b01)
      grant_id = REQ_0;
    else if (elig == 2'b10)
      grant_id = REQ_1;
  end

  alu_share_arbiter_alu u_alu (
    .sel    (req_sel[grant_id]),
    .data_1 (req_data_1[grant_id]),
    .data_2 (req_data_2[grant_id]),
    .shamt  (req_shamt[grant_id]),
    .result (alu_out)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign slot_free[gi] = ~rsp_valid_reg[gi] | rsp_ready[gi];
      assign elig[gi]      = req_valid[gi] & slot_free[gi];
      assign accept[gi]    = grant_valid & (grant_id == 1'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_data_reg[gi]  <= '0;
        end else if (accept[gi]) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_data_reg[gi]  <= alu_out;
        end else if (rsp_ready[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg       <= RR_INIT;
      last_grant_reg <= 1'b0;
      op_count_reg   <= '0;
    end else if (grant_valid) begin
      prio_reg       <= ~grant_id;
      last_grant_reg <= grant_id;
      if (op_count_reg != '1)
        op_count_reg <= op_count_reg + CNT_W'(1);
    end
  end

  assign req0_ready = accept[0];
  assign req1_ready = accept[1];
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp0_data  = rsp_data_reg[0];
  assign rsp1_data  = rsp_data_reg[1];
  assign last_grant = last_grant_reg;
  assign op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: expected results are queued at
// acceptance and compared while pending and when drained.
module tb_alu_share_arbiter;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic        v;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_sel, req1_sel;
  logic [31:0] req0_data_1, req0_data_2, req1_data_1, req1_data_2;
  logic [4:0]  req0_shamt, req1_shamt;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic last_grant;
  logic [TB_CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  logic        m_valid [2];
  logic        m_prio, m_last;
  int          m_cnt;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.RR_INIT(1'b0), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_data_1(req0_data_1), .req0_data_2(req0_data_2), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_data_1(req1_data_1), .req1_data_2(req1_data_2), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .last_grant(last_grant), .op_count(op_count)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input req_t r);
    case (r.sel)
      4'b0000: return r.a & r.b;
      4'b0001: return r.a | r.b;
      4'b0010: return r.a + r.b;
      4'b0011: return r.a - r.b;
      4'b0100: return (r.a < r.b) ? 32'd1 : 32'd0;
      4'b0101: return r.b << r.sh;
      4'b0110: return r.b >> r.sh;
      4'b0111: return 32'($signed(r.b) >>> r.sh);
      4'b1110: return r.a ^ r.b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic req_t mk(input logic v, input logic [3:0] sel,
                              input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    req_t r;
    r.v = v; r.sel = sel; r.a = a; r.b = b; r.sh = sh;
    return r;
  endfunction

  localparam req_t IDLE = '0;

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    m_prio = 1'b0; m_last = 1'b0; m_cnt = 0;
    q0.delete(); q1.delete();
    check_value("rst_rsp0_valid", rsp0_valid, 0);
    check_value("rst_rsp1_valid", rsp1_valid, 0);
    check_value("rst_rsp0_data", rsp0_data, 0);
    check_value("rst_rsp1_data", rsp1_data, 0);
    check_value("rst_last_grant", last_grant, 0);
    check_value("rst_op_count", op_count, 0);
    $display("reset: rsp_valid=%0d%0d op_count=%0d", rsp1_valid, rsp0_valid, op_count);
  endtask

  // One clock cycle: drive at negedge, predict, let the edge pass, check.
  task automatic run_cycle(input req_t a, input req_t b, input logic r0, input logic r1);
    logic e0, e1, g_v, g_id;
    req_t g;
    req0_valid = a.v; req0_sel = a.sel; req0_data_1 = a.a; req0_data_2 = a.b; req0_shamt = a.sh;
    req1_valid = b.v; req1_sel = b.sel; req1_data_1 = b.a; req1_data_2 = b.b; req1_shamt = b.sh;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    e0 = a.v && (!m_valid[0] || r0);
    e1 = b.v && (!m_valid[1] || r1);
    g_v = e0 || e1;
    g_id = (e0 && e1) ? m_prio : e1;
    check_value("req0_ready", req0_ready, g_v && !g_id);
    check_value("req1_ready", req1_ready, g_v && g_id);
    check_value("rsp0_valid", rsp0_valid, m_valid[0]);
    check_value("rsp1_valid", rsp1_valid, m_valid[1]);
    if (m_valid[0] && q0.size() > 0) begin
      check_value("rsp0_data", rsp0_data, q0[0]);
      if (r0) void'(q0.pop_front());
    end
    if (m_valid[1] && q1.size() > 0) begin
      check_value("rsp1_data", rsp1_data, q1[0]);
      if (r1) void'(q1.pop_front());
    end
    if (r0) m_valid[0] = 1'b0;
    if (r1) m_valid[1] = 1'b0;
    if (g_v) begin
      g = g_id ? b : a;
      if (g_id) q1.push_back(ref_alu(g)); else q0.push_back(ref_alu(g));
      m_valid[g_id] = 1'b1;
      m_last = g_id;
      m_prio = !g_id;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    @(negedge clk);
    check_value("last_grant", last_grant, m_last);
    check_value("op_count", op_count, m_cnt);
    $display("cycle: v=%0d%0d rdy=%0d%0d grant=%0d rsp0=%0d/0x%08h rsp1=%0d/0x%08h cnt=%0d",
             b.v, a.v, r1, r0, g_v ? int'(g_id) : -1, rsp0_valid, rsp0_data,
             rsp1_valid, rsp1_data, op_count);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_sel = 0; req1_sel = 0; req0_data_1 = 0; req0_data_2 = 0; req1_data_1 = 0;
    req1_data_2 = 0; req0_shamt = 0; req1_shamt = 0;
    @(negedge clk);
    do_reset();

    // Tie after reset goes to requester 0, then requester 1.
    run_cycle(mk(1, 4'b0010, 5, 7, 0), mk(1, 4'b0011, 5, 7, 0), 1, 1);
    check_value("add_5_7", rsp0_data, 32'd12);
    check_value("grant_first", last_grant, 0);
    run_cycle(IDLE, mk(1, 4'b0011, 5, 7, 0), 1, 1);
    check_value("sub_5_7", rsp1_data, 32'hFFFF_FFFE);
    check_value("grant_second", last_grant, 1);

    // Continuous contention with free slots alternates grants.
    for (int i = 0; i < 8; i++)
      run_cycle(mk(1, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom)),
                mk(1, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom)), 1, 1);

    // Fill both slots, then reset must clear them.
    run_cycle(mk(1, 4'b0010, 1, 2, 0), mk(1, 4'b0001, 4, 8, 0), 0, 0);
    run_cycle(mk(1, 4'b0010, 1, 2, 0), mk(1, 4'b0001, 4, 8, 0), 0, 0);
    check_value("both_pending", {30'b0, rsp1_valid, rsp0_valid}, 32'd3);
    do_reset();

    // Blocked slot 0 keeps req0 out while req1 streams.
    run_cycle(mk(1, 4'b0111, 0, 32'h8000_0000, 4), IDLE, 0, 1);
    check_value("sra_result", rsp0_data, 32'hF800_0000);
    for (int i = 0; i < 3; i++) begin
      run_cycle(mk(1, 4'b0000, 32'hF0F0, 32'h0FF0, 0), mk(1, 4'b0010, i, 100, 0), 0, 1);
      check_value("sra_hold", rsp0_data, 32'hF800_0000);
      check_value("bp_grant_req1", last_grant, 1);
    end
    run_cycle(mk(1, 4'b0000, 32'hF0F0, 32'h0FF0, 0), mk(1, 4'b0010, 9, 100, 0), 1, 1);
    check_value("reaccept_req0", last_grant, 0);
    check_value("and_result", rsp0_data, 32'h0000_00F0);

    // Same-cycle drain and refill on slot 1.
    run_cycle(IDLE, mk(1, 4'b0001, 1, 2, 0), 1, 0);
    run_cycle(IDLE, mk(1, 4'b1110, 32'hFF00, 32'h0FF0, 0), 1, 1);
    check_value("refill_valid", rsp1_valid, 1);
    check_value("xor_result", rsp1_data, 32'h0000_F0F0);

    // Undefined, NOP and unsigned compare.
    run_cycle(mk(1, 4'b1000, 32'h1234, 32'h5678, 3), IDLE, 1, 1);
    check_value("undef_zero", rsp0_data, 0);
    run_cycle(IDLE, mk(1, 4'b1111, 32'hFFFF, 32'h1, 1), 1, 1);
    check_value("nop_zero", rsp1_data, 0);
    run_cycle(mk(1, 4'b0100, 3, 9, 0), IDLE, 1, 1);
    check_value("slt_3_9", rsp0_data, 1);
    run_cycle(mk(1, 4'b0100, 9, 3, 0), IDLE, 1, 1);
    check_value("slt_9_3", rsp0_data, 0);

    // Drive past the counter's ceiling.
    for (int i = 0; i < 12; i++)
      run_cycle(mk(1, 4'b0010, i, 1, 0), mk(1, 4'b0011, i, 1, 0), 1, 1);
    check_value("op_count_sat", op_count, CNT_MAX);
    run_cycle(IDLE, IDLE, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 32-bit ALU instance between two requesters (e.g. the integer pipe and the multi-cycle mul/div sequencer) using round-robin arbitration. Each requester has a valid/ready request channel and a valid/ready response channel with a one-entry response register. At most one operation is issued to the ALU per cycle, and each result is registered for exactly one cycle of latency.

Parameters:
RR_INIT, 0, requester holding priority after reset (0 or 1)
CNT_W, 16, width of the saturating issued-operation counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_sel  in  4  ALU op select
req0_data_1  in  32  operand 1
req0_data_2  in  32  operand 2 (shift source)
req0_shamt  in  5  shift amount
req1_valid, req1_ready, req1_sel, req1_data_1, req1_data_2, req1_shamt  same as requester 0, for requester 1
rsp0_valid  out  1  result pending for requester 0
rsp0_ready  in  1  requester 0 consumes its result
rsp0_data  out  32  result for requester 0
rsp1_valid, rsp1_ready, rsp1_data  same as requester 0, for requester 1
last_grant  out  1  id of most recently accepted requester
op_count  out  CNT_W  saturating count of accepted operations

Behaviour:
- Clocking and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: rspN_valid=0, rspN_data=0, last_grant=0, op_count=0, priority pointer=RR_INIT. Reset mid-operation discards pending responses; no partial result survives.
- Slot free: slotN_free = ~rspN_valid | rspN_ready. This lets a response drain and a new result load in the same cycle.
- Eligibility: eligN = reqN_valid & slotN_free.
- Arbitration (combinational):
  - both eligible → grant the priority pointer's requester;
  - one eligible → grant it;
  - none → no grant.
- Ready: reqN_ready = grant==N. Ready may depend on valid; valid must never depend on ready.
- Accept: at the edge where reqN_valid & reqN_ready, the granted requester's sel/data_1/data_2/shamt drive the single shared ALU. Then: rspN_data <= alu_out, rspN_valid <= 1, last_grant <= N, priority pointer <= ~N, op_count += 1 (saturates at all-ones).
- No grant: priority pointer and last_grant hold.
- Latency: result visible on rspN_data exactly 1 cycle after acceptance. Throughput 1 op/cycle total.
- Drain: rspN_valid & rspN_ready with no new accept for N → rspN_valid <= 0. rspN_data holds its last value.
- Stability:
  - Requesters hold operands stable while valid & ~ready.
  - rspN_data is stable while rspN_valid & ~rspN_ready.
- Back-pressure: a requester with a full, undrained slot is ineligible. The other requester may be granted every cycle.
- ALU op encodings (shared constants): AND 0000, OR 0001, ADD 0010, SUB 0011, SLT 0100 (unsigned compare, result 1/0), SLL 0101, SRL 0110, SRA 0111, XOR 1110, NOP 1111. All other codes yield 0. Every code, including NOP and undefined ones, is handshaked normally.
- Arithmetic: 32-bit, wrap-around on ADD/SUB. Shifts use shamt on data_2. SRA sign-fills from data_2[31].

Decomposition:
- Package alu_pkg: 4-bit op-select constants listed above, plus requester-id constants.
- Sub-module: one instance of the team's existing ALU module. The arbiter contains only the operand mux, arbiter, response registers and counter. Optional helper rr_arb2 (2-way round-robin grant with pointer update).

Test Plan:
- Reset with RR_INIT=0, both req valid with ADD 5+7 (req0) and SUB 5-7 (req1) → cycle 1: req0 accepted, rsp0_data=12. Cycle 2: req1 accepted, rsp1_data=0xFFFFFFFE. last_grant 0 then 1.
- Both requesters valid continuously, rsp_ready=1 → grants alternate 0,1,0,1. op_count increments once per cycle.
- req0 SRA data_2=0x80000000 shamt=4, rsp0_ready=0 → rsp0_data=0xF8000000 holds. A second req0 op sees req0_ready=0 while req1 ops are granted every cycle. Raising rsp0_ready lets req0 be re-accepted in that same cycle.
- Same-cycle drain and refill: rsp1_valid=1, rsp1_ready=1, req1 XOR 0xFF00^0x0FF0 → rsp1_valid stays 1 and rsp1_data=0xF0F0 next cycle.
- Undefined sel 1000 and NOP 1111 → accepted, result 0. SLT 3<9 → 1; SLT 9<3 → 0.
- rst asserted while both responses pending → next cycle both rspN_valid=0, op_count=0, priority = RR_INIT. Force op_count to all-ones, then accept an op → op_count stays all-ones.
